vmem_responder: RTL and testbench
=================================

Name: vmem_responder

Overview:
- Byte-wide data-memory responder serving the processor's scalar memory port (MemRead / wren / address / data / q).
- Also services 4-byte vector bursts for vector load (VLOAD) and vector store (VSTORE).
- VLOAD: reads four consecutive bytes and packs them into one 32-bit word for the vector register file.
- VSTORE: unpacks a 32-bit word into four byte writes.
- Replaces the plain memory instance plus the processor-side byte-lane sequencing (T0..T3 loads, MemIn lane select).

Parameters:
- ADDR_W, 8, address width in bits; memory depth is 2^ADDR_W bytes.
- DATA_W, 8, scalar data width; vector word is 4*DATA_W.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- MemRead  in  1  scalar read strobe.
- wren  in  1  scalar write strobe.
- address  in  ADDR_W  scalar byte address.
- data  in  DATA_W  scalar write data.
- q  out  DATA_W  registered scalar read data.
- vreq  in  1  vector burst request, sampled in IDLE only.
- vwrite  in  1  burst direction, sampled with vreq: 1 = VSTORE, 0 = VLOAD.
- vaddr  in  ADDR_W  burst base address.
- vwdata  in  4*DATA_W  VSTORE word; lane 0 = [31:24].
- vrdata  out  4*DATA_W  VLOAD result; lane 0 = [31:24].
- vbusy  out  1  high while a burst is in progress.
- vdone  out  1  one-cycle pulse when a burst completes.

Behaviour:
- Reset (asynchronous):
  - q=0, vrdata=0, vbusy=0, vdone=0, state=IDLE, beat counter=0.
  - Storage contents are NOT cleared.
  - Reset mid-burst aborts the burst; bytes already written stay written.
- Storage: 2^ADDR_W x DATA_W array, one read/write access per cycle, shared by the scalar and burst paths.
- Scalar path (IDLE only):
  - wren=1 at an edge: mem[address] <= data.
  - MemRead=1 at an edge: q <= mem[address], visible the cycle after the edge (1-cycle latency); q holds when MemRead=0.
  - MemRead and wren together on the same address: q returns the old byte (read-before-write); the write still occurs.
- FSM states: IDLE, BURST, DONE.
- IDLE -> BURST: at an edge with vreq=1.
  - Captures vaddr into a base register, vwdata into a shadow register, and vwrite as the direction.
  - Clears the beat counter k; vbusy=1 from the following cycle.
  - A scalar access presented at this same edge is still performed.
- BURST: one beat per edge, k = 0,1,2,3.
  - Beat address = (base + k) mod 2^ADDR_W; wrap-around permitted (base 0xFE touches 0xFE, 0xFF, 0x00, 0x01).
  - VSTORE: mem[addr] <= shadow lane k.
  - VLOAD: vrdata lane k <= mem[addr]; other lanes hold.
  - After the beat with k=3 -> DONE.
- DONE: vdone=1 and vbusy=0 for exactly one cycle, then IDLE on the next edge.
  - vrdata holds until the next VLOAD beat overwrites it; VSTORE never changes vrdata.
- Latency: vreq edge E0, beats at E1..E4, vdone high during the cycle after E4, back in IDLE after E5. Total 5 edges.
- In BURST and DONE:
  - Scalar MemRead/wren are ignored: no write, q holds.
  - vreq is ignored (not queued); the requester must wait for vdone.
- Changes to vaddr/vwdata after the E0 capture have no effect on the burst in flight.
- Lane order is fixed: lane 0 = [31:24] = base address, lane 3 = [7:0] = base+3.

Test Plan:
- Reset, then scalar write 0x5A at 0x10; MemRead at 0x10 on the next edge -> q=0x5A one cycle later; q holds with MemRead=0.
- Scalar MemRead+wren same edge at 0x20 (old 0x11, new 0x22) -> q=0x11; a later read returns 0x22.
- VSTORE vaddr=0x40, vwdata=0xDEADBEEF -> vbusy high for 4 cycles, vdone pulse after E4; scalar reads 0x40..0x43 return DE, AD, BE, EF.
- VLOAD vaddr=0xFE with bytes FE:01, FF:02, 00:03, 01:04 -> vrdata=0x01020304 at vdone; the wrap is exercised.
- During a VSTORE, drive scalar wren at 0x50 and a second vreq -> 0x50 unchanged, no second burst, and vdone pulses exactly once.
- Assert reset after beat 1 of a VSTORE 0x11223344 at 0x60 -> outputs zero immediately; 0x60=0x11 and 0x61=0x22 retained; 0x62 and 0x63 unchanged.

Source files
------------

// File: rtl/vmem_responder.sv
// Byte-wide data memory serving the scalar port, plus a 4-beat burst engine
// that packs/unpacks 32-bit vector words for VLOAD and VSTORE.
module vmem_responder #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                MemRead,
   input  logic                wren,
   input  logic [ADDR_W-1:0]   address,
   input  logic [DATA_W-1:0]   data,
   output logic [DATA_W-1:0]   q,
   input  logic                vreq,
   input  logic                vwrite,
   input  logic [ADDR_W-1:0]   vaddr,
   input  logic [4*DATA_W-1:0] vwdata,
   output logic [4*DATA_W-1:0] vrdata,
   output logic                vbusy,
   output logic                vdone,
   output logic [1:0]          dbg_state
);

   // Burst handshake: vreq is taken only while idle (vbusy=0, vdone=0); once
   // taken, vbusy stays high for the four beats and vdone pulses for one cycle
   // at completion. Requests seen while busy or done are dropped, not queued.
   typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, DONE = 2'd2} state_t;

   state_t              state;
   logic [ADDR_W-1:0]   base;
   logic [4*DATA_W-1:0] shadow;
   logic                dir;
   logic [1:0]          k;
   logic [DATA_W-1:0]   mem [2**ADDR_W];

   logic [ADDR_W-1:0]   beat_addr;
   int                  lane_lsb;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_wdata;

   assign dbg_state = state;

   // One shared access port: scalar address while idle, beat address in a burst.
   always_comb begin
      beat_addr = base + ADDR_W'(k);
      lane_lsb  = (3 - int'(k)) * DATA_W;
      mem_we    = 1'b0;
      mem_addr  = address;
      mem_wdata = data;
      if (state == IDLE) begin
         mem_we = wren;
      end else if (state == BURST) begin
         mem_addr  = beat_addr;
         mem_we    = dir;
         mem_wdata = shadow[lane_lsb +: DATA_W];
      end
   end

   always_ff @(posedge clock) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         q      <= '0;
         vrdata <= '0;
         vbusy  <= 1'b0;
         vdone  <= 1'b0;
         k      <= 2'd0;
         base   <= '0;
         shadow <= '0;
         dir    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (MemRead) q <= mem[mem_addr];
               if (vreq) begin
                  state  <= BURST;
                  base   <= vaddr;
                  shadow <= vwdata;
                  dir    <= vwrite;
                  k      <= 2'd0;
                  vbusy  <= 1'b1;
               end
            end
            BURST: begin
               if (!dir) vrdata[lane_lsb +: DATA_W] <= mem[mem_addr];
               k <= k + 2'd1;
               if (k == 2'd3) begin
                  state <= DONE;
                  vbusy <= 1'b0;
                  vdone <= 1'b1;
               end
            end
            DONE: begin
               vdone <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vmem_responder.sv
// Bench for vmem_responder: scalar vector table, hand-written burst corner
// cases, then random scalar/burst traffic against an array-based memory model.
module tb_vmem_responder;
   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;

   logic        clock;
   logic        reset;
   logic        MemRead;
   logic        wren;
   logic [7:0]  address;
   logic [7:0]  data;
   logic [7:0]  q;
   logic        vreq;
   logic        vwrite;
   logic [7:0]  vaddr;
   logic [31:0] vwdata;
   logic [31:0] vrdata;
   logic        vbusy;
   logic        vdone;
   logic [1:0]  dbg_state;

   vmem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clock(clock), .reset(reset), .MemRead(MemRead), .wren(wren),
      .address(address), .data(data), .q(q), .vreq(vreq), .vwrite(vwrite),
      .vaddr(vaddr), .vwdata(vwdata), .vrdata(vrdata), .vbusy(vbusy),
      .vdone(vdone), .dbg_state(dbg_state)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  model_mem [256];
   logic [7:0]  model_q;
   logic [31:0] model_vrdata;
   logic [7:0]  exp_q [$];

   typedef struct {
      logic       rd;
      logic       wr;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_q;
   } vec_t;
   vec_t vecs [7];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   task automatic drive_idle();
      MemRead = 1'b0;
      wren    = 1'b0;
      vreq    = 1'b0;
      vwrite  = 1'b0;
   endtask

   // driver: one scalar access, q compared against the model one cycle later
   task automatic scalar_op(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
      MemRead = rd;
      wren    = wr;
      address = a;
      data    = d;
      if (rd) exp_q.push_back(model_mem[a]);
      tick();
      drive_idle();
      if (wr) model_mem[a] = d;
      if (rd) model_q = exp_q.pop_front();
      check("scalar_q", {24'd0, q}, {24'd0, model_q});
   endtask

   // driver: full burst, optionally with scalar traffic and a second vreq while busy
   task automatic run_burst(input logic wr, input logic [7:0] a, input logic [31:0] w,
                            input logic interfere, input logic [7:0] ia, input logic [7:0] id);
      logic [5:0] busy_seq;
      logic [5:0] done_seq;
      logic [7:0] ba;
      drive_idle();
      vreq   = 1'b1;
      vwrite = wr;
      vaddr  = a;
      vwdata = w;
      tick();
      vreq   = 1'b0;
      vaddr  = 8'($urandom);
      vwdata = $urandom;
      if (interfere) begin
         vreq    = 1'b1;
         vwrite  = ~wr;
         wren    = 1'b1;
         MemRead = 1'b1;
         address = ia;
         data    = id;
      end
      for (int c = 0; c < 6; c++) begin
         busy_seq[5-c] = vbusy;
         done_seq[5-c] = vdone;
         if (c < 5) tick();
      end
      drive_idle();
      for (int i = 0; i < 4; i++) begin
         ba = 8'(a + 8'(i));
         if (wr) model_mem[ba] = 8'(w >> (24 - 8 * i));
         else    model_vrdata = (model_vrdata & ~(32'hFF << (24 - 8 * i)))
                                | ({24'd0, model_mem[ba]} << (24 - 8 * i));
      end
      check("burst_vbusy_seq", {26'd0, busy_seq}, {26'd0, 6'b111100});
      check("burst_vdone_seq", {26'd0, done_seq}, {26'd0, 6'b000010});
      check("burst_q_hold", {24'd0, q}, {24'd0, model_q});
      check("burst_vrdata", vrdata, model_vrdata);
   endtask

   logic [7:0] st_bytes [4];
   int         op;
   logic [7:0] ra;
   logic [7:0] rd8;

   initial begin
      reset   = 1'b1;
      address = 8'h00;
      data    = 8'h00;
      vaddr   = 8'h00;
      vwdata  = 32'h0;
      drive_idle();
      repeat (2) @(posedge clock);
      #1;
      check("reset_q", {24'd0, q}, 32'h0);
      check("reset_vrdata", vrdata, 32'h0);
      check("reset_vbusy", {31'd0, vbusy}, 32'h0);
      check("reset_vdone", {31'd0, vdone}, 32'h0);
      reset        = 1'b0;
      model_q      = 8'h00;
      model_vrdata = 32'h0;

      vecs[0] = '{rd: 1'b0, wr: 1'b1, addr: 8'h10, wdata: 8'h5A, exp_q: 8'h00};
      vecs[1] = '{rd: 1'b1, wr: 1'b0, addr: 8'h10, wdata: 8'h00, exp_q: 8'h5A};
      vecs[2] = '{rd: 1'b0, wr: 1'b0, addr: 8'h10, wdata: 8'h00, exp_q: 8'h5A};
      vecs[3] = '{rd: 1'b0, wr: 1'b1, addr: 8'h20, wdata: 8'h11, exp_q: 8'h5A};
      vecs[4] = '{rd: 1'b1, wr: 1'b1, addr: 8'h20, wdata: 8'h22, exp_q: 8'h11};
      vecs[5] = '{rd: 1'b1, wr: 1'b0, addr: 8'h20, wdata: 8'h00, exp_q: 8'h22};
      vecs[6] = '{rd: 1'b1, wr: 1'b0, addr: 8'h10, wdata: 8'h00, exp_q: 8'h5A};
      for (int i = 0; i < 7; i++) begin
         MemRead = vecs[i].rd;
         wren    = vecs[i].wr;
         address = vecs[i].addr;
         data    = vecs[i].wdata;
         tick();
         drive_idle();
         if (vecs[i].wr) model_mem[vecs[i].addr] = vecs[i].wdata;
         check("vec_q", {24'd0, q}, {24'd0, vecs[i].exp_q});
      end
      model_q = vecs[6].exp_q;

      // give every byte a known value so later reads never see undefined storage
      for (int a = 0; a < 256; a++) scalar_op(1'b0, 1'b1, 8'(a), 8'($urandom));

      st_bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      run_burst(1'b1, 8'h40, 32'hDEADBEEF, 1'b0, 8'h00, 8'h00);
      for (int i = 0; i < 4; i++) begin
         scalar_op(1'b1, 1'b0, 8'(8'h40 + 8'(i)), 8'h00);
         check("vstore_byte", {24'd0, q}, {24'd0, st_bytes[i]});
      end

      scalar_op(1'b0, 1'b1, 8'hFE, 8'h01);
      scalar_op(1'b0, 1'b1, 8'hFF, 8'h02);
      scalar_op(1'b0, 1'b1, 8'h00, 8'h03);
      scalar_op(1'b0, 1'b1, 8'h01, 8'h04);
      run_burst(1'b0, 8'hFE, $urandom, 1'b0, 8'h00, 8'h00);
      check("vload_wrap", vrdata, 32'h01020304);

      run_burst(1'b1, 8'h44, $urandom, 1'b1, 8'h50, 8'($urandom));
      scalar_op(1'b1, 1'b0, 8'h50, 8'h00);

      drive_idle();
      vreq   = 1'b1;
      vwrite = 1'b1;
      vaddr  = 8'h60;
      vwdata = 32'h11223344;
      tick();
      vreq = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      #1;
      check("midreset_q", {24'd0, q}, 32'h0);
      check("midreset_vrdata", vrdata, 32'h0);
      check("midreset_vbusy", {31'd0, vbusy}, 32'h0);
      check("midreset_vdone", {31'd0, vdone}, 32'h0);
      model_mem[8'h60] = 8'h11;
      model_mem[8'h61] = 8'h22;
      model_q          = 8'h00;
      model_vrdata     = 32'h0;
      @(posedge clock);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) scalar_op(1'b1, 1'b0, 8'(8'h60 + 8'(i)), 8'h00);
      scalar_op(1'b1, 1'b0, 8'h60, 8'h00);
      check("midreset_kept", {24'd0, q}, 32'h11);

      for (int n = 0; n < 60; n++) begin
         op  = $urandom_range(0, 4);
         ra  = 8'($urandom);
         rd8 = 8'($urandom);
         case (op)
            0: scalar_op(1'b1, 1'b0, ra, rd8);
            1: scalar_op(1'b0, 1'b1, ra, rd8);
            2: scalar_op(1'b1, 1'b1, ra, rd8);
            3: run_burst(1'b0, ra, $urandom, 1'($urandom_range(0, 1)), 8'($urandom), rd8);
            default: run_burst(1'b1, ra, $urandom, 1'($urandom_range(0, 1)), 8'($urandom), rd8);
         endcase
      end

      for (int a = 0; a < 256; a += 17) scalar_op(1'b1, 1'b0, 8'(a), 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
